gfp8_nv_dot_acc: RTL and testbench

Parametrised, handshaked GFP8 native-vector dot-product engine with multi-NV accumulation, for the compute engine's K-loop. Each accepted beat carries one left/right native vector of NUM_GROUPS groups × GROUP_SIZE signed int8 mantissas, with one 5-bit exponent per group. The block computes the NV dot product, aligns it into a wide signed accumulator, and emits one GFP result (mantissa, exponent) per i_first..i_last sequence. Full valid/ready backpressure replaces the fixed free-running pipeline.

---
 rtl/gfp8_nv_dot_acc.sv | 219 +++++++++++++++++++++
 tb/tb_gfp8_nv_dot_acc.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfp8_nv_dot_acc.sv
// GFP8 native-vector dot product with multi-beat accumulation into a wide GFP result.
// Four stages: capture, per-group dot, exponent alignment, accumulate/output; one global stall.
module gfp8_nv_dot_acc #(
  parameter int NUM_GROUPS = 4,
  parameter int GROUP_SIZE = 32,
  parameter int EXP_BIAS   = 15,
  parameter int ACC_W      = 40
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic                               i_first,
  input  logic                               i_last,
  input  logic [8*NUM_GROUPS-1:0]            i_exp_left,
  input  logic [8*GROUP_SIZE*NUM_GROUPS-1:0] i_man_left,
  input  logic [8*NUM_GROUPS-1:0]            i_exp_right,
  input  logic [8*GROUP_SIZE*NUM_GROUPS-1:0] i_man_right,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [ACC_W-1:0]                   o_result_mantissa,
  output logic [7:0]                         o_result_exponent,
  output logic                               o_overflow
);
  localparam int NV_W = 8 * GROUP_SIZE * NUM_GROUPS;
  localparam int EX_W = 8 * NUM_GROUPS;
  localparam logic [8:0] ACC_W9 = 9'(ACC_W);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic stall;
  logic accept;

  assign stall   = o_valid && !i_ready;
  assign o_ready = !stall;
  assign accept  = i_valid && o_ready;

  // capture
  logic            s1_valid, s1_first, s1_last;
  logic [EX_W-1:0] s1_exp_l, s1_exp_r;
  logic [NV_W-1:0] s1_man_l, s1_man_r;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_exp_l <= '0;
      s1_exp_r <= '0;
      s1_man_l <= '0;
      s1_man_r <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= i_first;
        s1_last  <= i_last;
        s1_exp_l <= i_exp_left;
        s1_exp_r <= i_exp_right;
        s1_man_l <= i_man_left;
        s1_man_r <= i_man_right;
      end
    end
  end

  // per-group dot product and unbiased exponent
  logic signed [31:0] grp_sum [NUM_GROUPS];
  logic signed [7:0]  grp_exp [NUM_GROUPS];

  always_comb begin
    logic signed [7:0]  a;
    logic signed [7:0]  b;
    logic signed [15:0] p;
    a = '0;
    b = '0;
    p = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      grp_sum[g] = '0;
      for (int e = 0; e < GROUP_SIZE; e++) begin
        a = $signed(s1_man_l[(g*GROUP_SIZE+e)*8 +: 8]);
        b = $signed(s1_man_r[(g*GROUP_SIZE+e)*8 +: 8]);
        p = a * b;
        grp_sum[g] = grp_sum[g] + 32'(p);
      end
      grp_exp[g] = 8'(s1_exp_l[g*8 +: 5]) + 8'(s1_exp_r[g*8 +: 5]) - 8'(2*EXP_BIAS);
    end
  end

  logic               s2_valid, s2_first, s2_last;
  logic signed [31:0] s2_sum [NUM_GROUPS];
  logic signed [7:0]  s2_exp [NUM_GROUPS];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
        s2_sum[g] <= '0;
        s2_exp[g] <= '0;
      end
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      for (int g = 0; g < NUM_GROUPS; g++) begin
        s2_sum[g] <= grp_sum[g];
        s2_exp[g] <= grp_exp[g];
      end
    end
  end

  // align every group to the largest exponent; terms shifted 32 or more vanish entirely
  logic signed [7:0]       max_e;
  logic [7:0]              diff;
  logic signed [47:0]      wide;
  logic signed [ACC_W-1:0] nv_sum;

  always_comb begin
    max_e = s2_exp[0];
    for (int g = 1; g < NUM_GROUPS; g++)
      if (s2_exp[g] > max_e) max_e = s2_exp[g];
    diff = '0;
    wide = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      diff = max_e - s2_exp[g];
      if (diff < 8'd32) wide = wide + 48'(s2_sum[g] >>> diff);
    end
    nv_sum = wide[ACC_W-1:0];
  end

  logic                    s3_valid, s3_first, s3_last;
  logic signed [ACC_W-1:0] s3_sum;
  logic signed [7:0]       s3_exp;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s3_valid <= 1'b0;
      s3_first <= 1'b0;
      s3_last  <= 1'b0;
      s3_sum   <= '0;
      s3_exp   <= '0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      s3_first <= s2_first;
      s3_last  <= s2_last;
      s3_sum   <= nv_sum;
      s3_exp   <= max_e;
    end
  end

  // accumulate
  function automatic logic signed [ACC_W-1:0] shr(input logic signed [ACC_W-1:0] x,
                                                  input logic [8:0] n);
    if (n >= ACC_W9) return {ACC_W{x[ACC_W-1]}};
    return x >>> n;
  endfunction

  logic signed [ACC_W-1:0] acc;
  logic signed [7:0]       acc_e;
  logic                    ovf;
  logic signed [8:0]       ediff;
  logic [8:0]              shamt;
  logic signed [ACC_W-1:0] a_al, b_al;
  logic signed [ACC_W:0]   total;
  logic                    sat;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [7:0]       acc_e_next;
  logic                    ovf_next;

  always_comb begin
    ediff      = $signed({acc_e[7], acc_e}) - $signed({s3_exp[7], s3_exp});
    shamt      = ediff[8] ? 9'(-ediff) : 9'(ediff);
    a_al       = acc;
    b_al       = s3_sum;
    acc_e_next = acc_e;
    if (s3_first) begin
      a_al       = '0;
      acc_e_next = s3_exp;
    end else if (ediff[8]) begin
      a_al       = shr(acc, shamt);
      acc_e_next = s3_exp;
    end else begin
      b_al = shr(s3_sum, shamt);
    end
    total    = $signed({a_al[ACC_W-1], a_al}) + $signed({b_al[ACC_W-1], b_al});
    sat      = total[ACC_W] != total[ACC_W-1];
    acc_next = sat ? (total[ACC_W] ? SAT_MIN : SAT_MAX) : total[ACC_W-1:0];
    ovf_next = (!s3_first && ovf) || sat;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc               <= '0;
      acc_e             <= '0;
      ovf               <= 1'b0;
      o_valid           <= 1'b0;
      o_result_mantissa <= '0;
      o_result_exponent <= '0;
      o_overflow        <= 1'b0;
    end else if (!stall) begin
      o_valid <= s3_valid && s3_last;
      if (s3_valid) begin
        acc   <= acc_next;
        acc_e <= acc_e_next;
        ovf   <= ovf_next;
        if (s3_last) begin
          o_result_mantissa <= acc_next;
          o_result_exponent <= acc_e_next;
          o_overflow        <= ovf_next;
        end
      end
    end
  end

  // upper exponent bits and the guard bits of the group sum carry no information
  logic unused_bits;
  assign unused_bits = ^{s1_exp_l, s1_exp_r, wide};

endmodule

// File: tb/tb_gfp8_nv_dot_acc.sv
// Directed bench for gfp8_nv_dot_acc with an arithmetic reference model and result queue.
module tb_gfp8_nv_dot_acc;
  localparam int NG   = 4;
  localparam int GS   = 32;
  localparam int BIAS = 15;
  localparam int ACC  = 24;
  localparam int NVW  = 8 * GS * NG;
  localparam int EXW  = 8 * NG;
  localparam longint MAXV = (longint'(1) <<< (ACC - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC - 1));

  logic           clk = 1'b0;
  logic           i_reset;
  logic           i_valid, i_first, i_last, i_ready;
  logic           o_ready, o_valid, o_overflow;
  logic [EXW-1:0] i_exp_left, i_exp_right;
  logic [NVW-1:0] i_man_left, i_man_right;
  logic [ACC-1:0] o_result_mantissa;
  logic [7:0]     o_result_exponent;

  gfp8_nv_dot_acc #(.NUM_GROUPS(NG), .GROUP_SIZE(GS), .EXP_BIAS(BIAS), .ACC_W(ACC)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_first(i_first), .i_last(i_last),
    .i_exp_left(i_exp_left), .i_man_left(i_man_left),
    .i_exp_right(i_exp_right), .i_man_right(i_man_right),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_result_mantissa(o_result_mantissa), .o_result_exponent(o_result_exponent),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint man;
    int     ex;
    bit     ovf;
  } res_t;

  res_t   q[$];
  res_t   last_res;
  int     checks = 0;
  int     errors = 0;
  int     n_results = 0;
  int     seen = 0;
  longint macc = 0;
  int     mexp = 0;
  bit     movf = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint ashr(input longint x, input int d);
    if (d >= ACC) return (x < 0) ? -1 : 0;
    return x >>> d;
  endfunction

  // reference: dot each group, align to the largest exponent, accumulate with saturation
  task automatic model_accept(input bit f, input bit l, input logic [EXW-1:0] exl,
                              input logic [EXW-1:0] exr, input logic [NVW-1:0] ml,
                              input logic [NVW-1:0] mr);
    int     s[NG];
    int     e[NG];
    int     me;
    longint nv, sum;
    int     ne;
    byte    a, b;
    res_t   r;
    nv = 0;
    for (int g = 0; g < NG; g++) begin
      s[g] = 0;
      for (int k = 0; k < GS; k++) begin
        a = ml[(g*GS+k)*8 +: 8];
        b = mr[(g*GS+k)*8 +: 8];
        s[g] = s[g] + int'(a) * int'(b);
      end
      e[g] = int'(exl[g*8 +: 5]) + int'(exr[g*8 +: 5]) - 2 * BIAS;
    end
    me = e[0];
    for (int g = 1; g < NG; g++) if (e[g] > me) me = e[g];
    for (int g = 0; g < NG; g++)
      if (me - e[g] < 32) nv = nv + longint'(s[g] >>> (me - e[g]));
    nv = (nv <<< (64 - ACC)) >>> (64 - ACC);
    if (f) begin
      sum = nv; ne = me; movf = 0;
    end else if (mexp >= me) begin
      sum = macc + ashr(nv, mexp - me); ne = mexp;
    end else begin
      sum = ashr(macc, me - mexp) + nv; ne = me;
    end
    if (sum > MAXV) begin sum = MAXV; movf = 1; end
    if (sum < MINV) begin sum = MINV; movf = 1; end
    macc = sum;
    mexp = ne;
    if (l) begin
      r.man = macc; r.ex = mexp; r.ovf = movf;
      q.push_back(r);
    end
  endtask

  task automatic mreset();
    macc = 0; mexp = 0; movf = 0;
    q.delete();
  endtask

  task automatic send(input bit f, input bit l, input logic [EXW-1:0] exl,
                      input logic [EXW-1:0] exr, input logic [NVW-1:0] ml,
                      input logic [NVW-1:0] mr);
    int n;
    bit rdy;
    n = 0;
    @(negedge clk);
    i_valid = 1; i_first = f; i_last = l;
    i_exp_left = exl; i_exp_right = exr; i_man_left = ml; i_man_right = mr;
    while (1) begin
      #1;
      rdy = o_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept(f, l, exl, exr, ml, mr);
        break;
      end
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: beat not accepted after %0d cycles, required acceptance", n);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 0; i_first = 0; i_last = 0;
  endtask

  task automatic send_seq(input int n, input logic [EXW-1:0] exl, input logic [EXW-1:0] exr,
                          input logic [NVW-1:0] ml, input logic [NVW-1:0] mr);
    for (int i = 0; i < n; i++) send(i == 0, i == n - 1, exl, exr, ml, mr);
    idle();
  endtask

  task automatic wait_res(input int n);
    int t;
    t = 0;
    while (n_results < seen + n && t < 300) begin
      @(negedge clk); #3; t++;
    end
    chk("result_count", n_results - seen, n);
    seen = n_results;
  endtask

  // compare outputs with the head of the expected queue whenever a result is presented
  always begin
    @(negedge clk); #2;
    if (i_reset === 1'b0 && o_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: o_valid=1 mantissa %0d, required no result",
                 $signed(o_result_mantissa));
      end else begin
        chk("result_mantissa", $signed(o_result_mantissa), q[0].man);
        chk("result_exponent", $signed(o_result_exponent), q[0].ex);
        chk("result_overflow", o_overflow, q[0].ovf);
        if (i_ready) begin
          last_res = q.pop_front();
          n_results++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  logic [NVW-1:0] m01, mff, m7f;
  logic [EXW-1:0] e15, e16g0;
  int             lat;

  initial begin
    m01 = {(NG*GS){8'h01}};
    mff = {(NG*GS){8'hFF}};
    m7f = {(NG*GS){8'h7F}};
    e15 = {NG{8'd15}};
    e16g0 = e15;
    e16g0[7:0] = 8'd16;
    i_reset = 1; i_valid = 0; i_first = 0; i_last = 0; i_ready = 1;
    i_exp_left = '0; i_exp_right = '0; i_man_left = '0; i_man_right = '0;
    mreset();
    repeat (3) @(negedge clk);
    #2;
    chk("reset_o_valid", o_valid, 0);
    chk("reset_mantissa", o_result_mantissa, 0);
    chk("reset_exponent", o_result_exponent, 0);
    chk("reset_overflow", o_overflow, 0);
    @(negedge clk);
    i_reset = 0;
    @(negedge clk); #2;
    chk("o_ready_after_reset", o_ready, 1);

    // single NV, ones everywhere: 128 products of 1
    send(1, 1, e15, e15, m01, m01);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin i_valid = 0; i_first = 0; i_last = 0; end
      #2;
      if (o_valid) begin lat = k; break; end
    end
    chk("latency", lat, 4);
    wait_res(1);
    chk("single_mantissa", last_res.man, 128);
    chk("single_exponent", last_res.ex, 0);
    chk("single_overflow", last_res.ovf, 0);

    // group 0 one exponent higher: 32 + 3*16
    send_seq(1, e16g0, e15, m01, m01);
    wait_res(1);
    chk("align_mantissa", last_res.man, 80);
    chk("align_exponent", last_res.ex, 1);

    send_seq(1, e15, e15, mff, m01);
    wait_res(1);
    chk("negative_mantissa", last_res.man, -128);

    send_seq(3, e15, e15, m01, m01);
    wait_res(1);
    chk("three_beat_mantissa", last_res.man, 384);
    chk("three_beat_exponent", last_res.ex, 0);

    send_seq(4, e15, e15, m7f, m7f);
    wait_res(1);
    chk("four_beat_mantissa", last_res.man, 8258048);
    chk("four_beat_overflow", last_res.ovf, 0);

    send_seq(5, e15, e15, m7f, m7f);
    wait_res(1);
    chk("sat_mantissa", last_res.man, 8388607);
    chk("sat_overflow", last_res.ovf, 1);

    // backpressure: five single-NV results, downstream blocked for five cycles
    @(negedge clk);
    i_ready = 0;
    fork
      begin
        send(1, 1, e15, e15, m01, m01);
        send(1, 1, e16g0, e15, m01, m01);
        send(1, 1, e15, e15, mff, m01);
        send(1, 1, e15, e15, m01, m01);
        send(1, 1, e16g0, e15, m01, m01);
        idle();
      end
      begin
        int t;
        t = 0;
        do begin @(negedge clk); #2; t++; end while (!o_valid && t < 50);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) begin @(negedge clk); #2; end
          chk("stall_o_ready", o_ready, 0);
          chk("stall_o_valid", o_valid, 1);
        end
        @(negedge clk);
        i_ready = 1;
      end
    join
    wait_res(5);
    chk("bp_last_mantissa", last_res.man, 80);
    chk("bp_last_exponent", last_res.ex, 1);

    // reset with a closing beat still in flight: nothing may emerge afterwards
    send(1, 0, e15, e15, m01, m01);
    send(0, 1, e15, e15, m01, m01);
    @(negedge clk);
    i_valid = 0; i_first = 0; i_last = 0;
    i_reset = 1;
    mreset();
    #2;
    chk("midreset_o_valid", o_valid, 0);
    chk("midreset_mantissa", o_result_mantissa, 0);
    chk("midreset_exponent", o_result_exponent, 0);
    chk("midreset_overflow", o_overflow, 0);
    repeat (2) @(negedge clk);
    i_reset = 0;
    repeat (10) @(negedge clk);
    #2;
    chk("no_stale_result", o_valid, 0);

    send_seq(1, e15, e15, mff, m01);
    wait_res(1);
    chk("post_reset_mantissa", last_res.man, -128);
    chk("post_reset_overflow", last_res.ovf, 0);

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
